// File: rtl/vslc_eeprom_fetch.sv
// ---------------------------------------------------------------------------
// vslc_eeprom_fetch
//   SPI EEPROM read front-end for the VSLC core. Issues a sequential READ
//   (0x03) at a given address to a 25xx-style EEPROM. It then streams program
//   bytes to the instruction executor over a valid/ready byte interface. SCK
//   is stalled (held low, cs_n kept asserted) while the consumer applies
//   backpressure.
//
// Parameters
//   ADDR_W          EEPROM address width in bits (8 or 16)
//   SCK_DIV         SCK half-period in clk cycles (>= 1)
//   CS_HIGH_CYCLES  minimum cs_n deassert time after a read is aborted
//
// Ports
//   clk, rst_n            clock (rising edge), synchronous active-low reset
//   i_start, i_start_addr begin a read at i_start_addr (IDLE only)
//   i_abort               end the current read and deassert cs_n
//   o_busy                high from start accept until back in IDLE
//   o_byte_data/addr      fetched byte and its EEPROM address
//   o_byte_valid          byte output valid
//   i_byte_ready          consumer ready
//   o_spi_sck/cs_n/copi   SPI mode 0 controller outputs
//   i_spi_cipo            SPI controller input, sampled as SCK rises
//
// Configuration
//   VSLC_FETCH_SKID_EN  when defined, adds a one-byte skid buffer. The next
//                       byte keeps shifting while the output is held.
//                       Otherwise a single output register is used, and SCK
//                       stalls whenever a byte sits unaccepted.
//
// Handshake: a byte transfers on any clk edge where o_byte_valid and
// i_byte_ready are both high. While o_byte_valid is high and i_byte_ready is
// low, o_byte_data and o_byte_addr hold their values. o_byte_valid never
// drops without an accept, except on abort or reset.
// ---------------------------------------------------------------------------
module vslc_eeprom_fetch #(
  parameter int ADDR_W         = 8,
  parameter int SCK_DIV        = 1,
  parameter int CS_HIGH_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_start_addr,
  input  logic              i_abort,
  output logic              o_busy,
  output logic [7:0]        o_byte_data,
  output logic [ADDR_W-1:0] o_byte_addr,
  output logic              o_byte_valid,
  input  logic              i_byte_ready,
  output logic              o_spi_sck,
  output logic              o_spi_cs_n,
  output logic              o_spi_copi,
  input  logic              i_spi_cipo
);

  localparam int DIV_W = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
  localparam int CSC_W = (CS_HIGH_CYCLES > 1) ? $clog2(CS_HIGH_CYCLES) : 1;
  localparam int BIT_W = 5;
  localparam int TX_W  = 8 + ADDR_W;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCK_DIV - 1);
  localparam logic [CSC_W-1:0] CSC_LAST  = CSC_W'(CS_HIGH_CYCLES - 1);
  localparam logic [BIT_W-1:0] BYTE_LAST = BIT_W'(7);
  localparam logic [BIT_W-1:0] ADDR_LAST = BIT_W'(ADDR_W - 1);
  localparam logic [7:0]       READ_CMD  = 8'h03;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CS_SETUP,
    S_CMD,
    S_ADDR,
    S_DATA,
    S_HOLD,
    S_CS_HIGH
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic                r_cs_n;
  logic                r_sck;
  logic                r_copi;
  logic [DIV_W-1:0]    r_div;       // clk count within the current SCK phase
  logic [BIT_W-1:0]    r_bit;       // slot index within CMD / ADDR / DATA
  logic [TX_W-1:0]     r_tx;        // command + address, shifted out MSB first
  logic [7:0]          r_rx;        // incoming byte, shifted in MSB first
  logic [CSC_W-1:0]    r_cs_cnt;
  logic [7:0]          r_data;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_valid;
  logic [ADDR_W-1:0]   r_next_addr; // address of the byte currently shifting
`ifdef VSLC_FETCH_SKID_EN
  logic [7:0]          r_skid_data;
  logic [ADDR_W-1:0]   r_skid_addr;
  logic                r_skid_valid;
`endif

  logic w_slot_tick;
  logic w_high_end;
  logic w_bit_last;
  logic w_accept;
  logic w_byte_done;
  logic w_need_hold;
  logic w_abort;

  assign w_slot_tick = (r_div == DIV_LAST);
  assign w_high_end  = w_slot_tick & r_sck;
  assign w_bit_last  = (r_state == S_ADDR) ? (r_bit == ADDR_LAST) : (r_bit == BYTE_LAST);
  assign w_accept    = r_valid & i_byte_ready;
  assign w_byte_done = (r_state == S_DATA) & w_high_end & w_bit_last;
  assign w_abort     = i_abort & (r_state != S_IDLE);

`ifdef VSLC_FETCH_SKID_EN
  // No space only when the skid already holds a finished byte and the output
  // is not being drained this cycle.
  assign w_need_hold = r_skid_valid & ~i_byte_ready;
`else
  // Single output register: stall as soon as a byte sits unaccepted.
  assign w_need_hold = r_valid & ~i_byte_ready;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    if (w_abort) begin
      w_state_nxt = S_CS_HIGH;
    end else begin
      case (r_state)
        // abort in IDLE beats a simultaneous start
        S_IDLE:     if (i_start && !i_abort) w_state_nxt = S_CS_SETUP;
        S_CS_SETUP: if (w_slot_tick) w_state_nxt = S_CMD;
        S_CMD:      if (w_high_end && w_bit_last) w_state_nxt = S_ADDR;
        S_ADDR:     if (w_high_end && w_bit_last) w_state_nxt = S_DATA;
        // Stalls are only taken with SCK low so a slot is never cut short
        // while high.
        S_DATA:     if (!r_sck && w_need_hold) w_state_nxt = S_HOLD;
        S_HOLD:     if (!w_need_hold) w_state_nxt = S_DATA;
        S_CS_HIGH:  if (r_cs_cnt == CSC_LAST) w_state_nxt = S_IDLE;
        default:    w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Datapath, SPI pins and output buffers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cs_n       <= 1'b1;
      r_sck        <= 1'b0;
      r_copi       <= 1'b0;
      r_div        <= '0;
      r_bit        <= '0;
      r_tx         <= '0;
      r_rx         <= '0;
      r_cs_cnt     <= '0;
      r_data       <= '0;
      r_addr       <= '0;
      r_valid      <= 1'b0;
      r_next_addr  <= '0;
`ifdef VSLC_FETCH_SKID_EN
      r_skid_data  <= '0;
      r_skid_addr  <= '0;
      r_skid_valid <= 1'b0;
`endif
    end else begin
      r_cs_n <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_CS_HIGH);

      if (w_abort) begin
        r_sck        <= 1'b0;
        r_copi       <= 1'b0;
        r_div        <= '0;
        r_bit        <= '0;
        r_cs_cnt     <= '0;
        r_valid      <= 1'b0;
`ifdef VSLC_FETCH_SKID_EN
        r_skid_valid <= 1'b0;
`endif
      end else begin
        // Output buffer management
`ifdef VSLC_FETCH_SKID_EN
        if (w_accept) begin
          if (r_skid_valid) begin
            r_data       <= r_skid_data;
            r_addr       <= r_skid_addr;
            r_skid_valid <= 1'b0;
          end else begin
            r_valid <= 1'b0;
          end
        end
        if (w_byte_done) begin
          if (!r_valid || (w_accept && !r_skid_valid)) begin
            r_data  <= r_rx;
            r_addr  <= r_next_addr;
            r_valid <= 1'b1;
          end else begin
            r_skid_data  <= r_rx;
            r_skid_addr  <= r_next_addr;
            r_skid_valid <= 1'b1;
          end
          r_next_addr <= r_next_addr + 1'b1;
        end
`else
        if (w_accept) begin
          r_valid <= 1'b0;
        end
        // The stall guarantees the output is free (or draining) here.
        if (w_byte_done) begin
          r_data      <= r_rx;
          r_addr      <= r_next_addr;
          r_valid     <= 1'b1;
          r_next_addr <= r_next_addr + 1'b1;
        end
`endif

        case (r_state)
          S_IDLE: begin
            if (w_state_nxt == S_CS_SETUP) begin
              r_tx        <= {READ_CMD, i_start_addr};
              r_next_addr <= i_start_addr;
              r_div       <= '0;
            end
          end
          S_CS_SETUP: begin
            if (w_slot_tick) begin
              // First command bit is presented at the start of slot 0.
              r_div  <= '0;
              r_bit  <= '0;
              r_copi <= r_tx[TX_W-1];
              r_tx   <= {r_tx[TX_W-2:0], 1'b0};
            end else begin
              r_div <= r_div + 1'b1;
            end
          end
          S_CMD, S_ADDR, S_DATA: begin
            if (w_state_nxt == S_HOLD) begin
              r_div <= '0;
            end else if (w_slot_tick) begin
              r_div <= '0;
              r_sck <= ~r_sck;
              if (!r_sck) begin
                // SCK about to rise: capture cipo on this edge.
                r_rx <= {r_rx[6:0], i_spi_cipo};
              end else begin
                // End of slot: SCK falls, next slot begins, copi updates.
                r_bit <= w_bit_last ? '0 : r_bit + 1'b1;
                if ((r_state == S_DATA) || ((r_state == S_ADDR) && w_bit_last)) begin
                  r_copi <= 1'b0;
                end else begin
                  r_copi <= r_tx[TX_W-1];
                  r_tx   <= {r_tx[TX_W-2:0], 1'b0};
                end
              end
            end else begin
              r_div <= r_div + 1'b1;
            end
          end
          S_CS_HIGH: begin
            r_cs_cnt <= r_cs_cnt + 1'b1;
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign o_busy       = (r_state != S_IDLE);
  assign o_byte_data  = r_data;
  assign o_byte_addr  = r_addr;
  assign o_byte_valid = r_valid;
  assign o_spi_sck    = r_sck;
  assign o_spi_cs_n   = r_cs_n;
  assign o_spi_copi   = r_copi;

endmodule
